// File: rtl/div_if.sv
// div_if: EX-stage <-> divider handshake bundle
// master (EX side) drives div_start/div_signed/div_cancel/opr1/opr2.
// slave (divider) drives div_ready/div_busy/div_quo/div_rem.
interface div_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic             div_signed;
  logic             div_cancel;
  logic [WIDTH-1:0] opr1;
  logic [WIDTH-1:0] opr2;
  logic             div_ready;
  logic             div_busy;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  modport master (output div_start, div_signed, div_cancel, opr1, opr2,
                  input  div_ready, div_busy, div_quo, div_rem);
  modport slave  (input  div_start, div_signed, div_cancel, opr1, opr2,
                  output div_ready, div_busy, div_quo, div_rem);
endinterface

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle
// Ports:
//   clk, rst (sync, active-high).
//   d (div_if.slave): start/signed/cancel/opr1/opr2 in; ready/busy/quo/rem out.
// Optional macro DIV_EARLY_OUT_EN: |opr1| < |opr2| finishes one cycle after accept.
module div_iter #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] pr, dvd, dsr, a_mag, b_mag, q_nxt, r_nxt;
  logic [WIDTH:0] sh, diff;
  logic [CW-1:0] cnt;
  logic sign_q, sign_r, early;
  always_comb begin
    a_mag = d.div_signed && d.opr1[WIDTH-1] ? -d.opr1 : d.opr1;
    b_mag = d.div_signed && d.opr2[WIDTH-1] ? -d.opr2 : d.opr2;
    sh    = {pr, dvd[WIDTH-1]};
    diff  = sh - {1'b0, dsr};
    q_nxt = {dvd[WIDTH-2:0], ~diff[WIDTH]};
    r_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
`ifdef DIV_EARLY_OUT_EN
    early = a_mag < b_mag;
`else
    early = 1'b0;
`endif
  end
  // dvd doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      d.div_ready <= 1'b0;
      d.div_busy  <= 1'b0;
      d.div_quo   <= '0;
      d.div_rem   <= '0;
      cnt         <= '0;
      pr          <= '0;
      dvd         <= '0;
      dsr         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else begin
      d.div_ready <= 1'b0;
      case (state)
        IDLE: if (!d.div_cancel && d.div_start) begin
          sign_q <= d.div_signed & (d.opr1[WIDTH-1] ^ d.opr2[WIDTH-1]);
          sign_r <= d.div_signed & d.opr1[WIDTH-1];
          dvd    <= a_mag;
          dsr    <= b_mag;
          pr     <= '0;
          cnt    <= '0;
          if (d.opr2 == '0 || early) begin
            state       <= DONE;
            d.div_ready <= 1'b1;
            d.div_quo   <= d.opr2 == '0 ? '1 : '0;
            d.div_rem   <= d.opr1;
          end else begin
            state      <= BUSY;
            d.div_busy <= 1'b1;
          end
        end
        BUSY: if (d.div_cancel) begin
          state      <= IDLE;
          d.div_busy <= 1'b0;
        end else begin
          pr  <= r_nxt;
          dvd <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            d.div_busy  <= 1'b0;
            d.div_ready <= 1'b1;
            d.div_quo   <= sign_q ? -q_nxt : q_nxt;
            d.div_rem   <= sign_r ? -r_nxt : r_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: table, random and corner-sequence checks of div_iter against an arithmetic model
module tb_div_iter;
  logic clk = 1'b0, rst = 1'b1;
  int nvec = 0, nbad = 0;
  div_if #(.WIDTH(32)) bus();
  div_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .d(bus.slave));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a, b; logic s; logic [31:0] q, r;} vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? 32'(-x) : x;
  endfunction
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sa, sb;
    lat = 33;
    if (b == 0) begin
      q = '1; r = a; lat = 1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
`ifdef DIV_EARLY_OUT_EN
    if (b != 0 && mag(a, s) < mag(b, s)) begin
      q = '0; r = a; lat = 1;
    end
`endif
  endfunction
  task automatic run(input string n, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] q, input logic [31:0] r, input int lat);
    int cyc = 0;
    bus.opr1 = a; bus.opr2 = b; bus.div_signed = s; bus.div_start = 1'b1;
    while (cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.div_ready) break;
    end
    bus.div_start = 1'b0;
    chk({n, " latency"}, 32'(cyc), 32'(lat));
    chk({n, " quo"}, bus.div_quo, q);
    chk({n, " rem"}, bus.div_rem, r);
    @(negedge clk);
    chk({n, " pulse"}, {31'b0, bus.div_ready}, 32'd0);
    chk({n, " hold"}, bus.div_quo, q);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic [31:0] a, b, q, r;
    logic s;
    int lat;
    bus.div_start = 0; bus.div_signed = 0; bus.div_cancel = 0; bus.opr1 = 0; bus.opr2 = 0;
    repeat (3) @(negedge clk);
    chk("rst ready", {31'b0, bus.div_ready}, 0);
    chk("rst busy", {31'b0, bus.div_busy}, 0);
    chk("rst quo", bus.div_quo, 0);
    chk("rst rem", bus.div_rem, 0);
    rst = 1'b0;
    tbl.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2});
    tbl.push_back('{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF});
    tbl.push_back('{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1});
    tbl.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0});
    tbl.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0});
    tbl.push_back('{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5});
    tbl.push_back('{32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB});
    tbl.push_back('{32'd3, 32'd10, 1'b0, 32'd0, 32'd3});
    tbl.push_back('{32'hFFFFFFFD, 32'd10, 1'b1, 32'd0, 32'hFFFFFFFD});
    tbl.push_back('{32'd0, 32'd9, 1'b0, 32'd0, 32'd0});
    tbl.push_back('{32'h80000000, 32'd1, 1'b0, 32'h80000000, 32'd0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0});
    foreach (tbl[i]) begin
      lat = 33;
      if (tbl[i].b == 0) lat = 1;
`ifdef DIV_EARLY_OUT_EN
      else if (mag(tbl[i].a, tbl[i].s) < mag(tbl[i].b, tbl[i].s)) lat = 1;
`endif
      run($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, lat);
    end
    bus.opr1 = 100; bus.opr2 = 7; bus.div_signed = 0; bus.div_start = 1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("cancel busy before", {31'b0, bus.div_busy}, 1);
    bus.div_start = 0; bus.div_cancel = 1;
    @(negedge clk);
    bus.div_cancel = 0;
    chk("cancel busy after", {31'b0, bus.div_busy}, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_ready) chk("cancel no ready", 1, 0);
    end
    run("after cancel", 9, 3, 0, 3, 0, 33);
    bus.opr1 = 50; bus.opr2 = 5; bus.div_start = 1; bus.div_cancel = 1;
    @(negedge clk);
    bus.div_start = 0; bus.div_cancel = 0;
    chk("cancel beats start", {31'b0, bus.div_busy | bus.div_ready}, 0);
    idle(2);
    bus.opr1 = 100; bus.opr2 = 7; bus.div_start = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1;
    bus.div_start = 0;
    @(negedge clk);
    rst = 0;
    chk("midrst busy", {31'b0, bus.div_busy}, 0);
    chk("midrst quo", bus.div_quo, 0);
    chk("midrst rem", bus.div_rem, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_ready) chk("midrst no ready", 1, 0);
    end
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(0, 15));
        1: b = 0;
        2: a = 32'($urandom_range(0, 40));
        default: ;
      endcase
      s = 1'($urandom);
      ref_div(a, b, s, q, r, lat);
      run($sformatf("rnd%0d", i), a, b, s, q, r, lat);
      idle($urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
